reversible_serial_adder: RTL and testbench
==========================================

REVERSIBLE_SERIAL_ADDER -- requirements
Module: reversible_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which is the operand width in bits (>=2).
REQ-002 SHALL have parameter DIGIT, default 1, which is the number of bits processed per cycle; it must divide WIDTH.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request offered.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 mode  input  1  0 = forward add, 1 = reverse (uncompute).
REQ-008 a  input  WIDTH  operand A, preserved.
REQ-009 b  input  WIDTH  operand B (forward) or sum S (reverse), preserved.
REQ-010 cin  input  1  carry-in.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 a_out  output  WIDTH  captured a.
REQ-014 b_out  output  WIDTH  captured b.
REQ-015 res  output  WIDTH  result.
REQ-016 cout  output  1  carry-out of the forward relation.
REQ-017 busy  output  1  high in RUN state.

Function
REQ-018 SHALL implement three states: IDLE, RUN and DONE.
- in_ready = (state==IDLE).
- busy = (state==RUN).
- out_valid = (state==DONE).
REQ-019 SHALL accept a request on a rising edge where in_valid && in_ready.
- Capture a, b, cin and mode.
- Clear res.
- Load the digit counter with WIDTH/DIGIT.
- Go to RUN.
REQ-020 SHALL ignore in_valid and all operand inputs outside IDLE; captured values SHALL NOT change until the next acceptance.
REQ-021 SHALL process one DIGIT-bit slice per RUN cycle, LSB slice first, propagating the internal carry or borrow between slices.
REQ-022 SHALL move to DONE on the edge that processes the last slice, so out_valid rises exactly WIDTH/DIGIT edges after the accepting edge.
REQ-023 In forward mode, SHALL compute {cout,res} = a + b + cin, using a (WIDTH+1)-bit result.
REQ-024 In reverse mode, SHALL compute res = (b - a - cin) mod 2^WIDTH, with cout = 1 iff a + cin > b (unsigned), so that a + res + cin = b + cout*2^WIDTH holds.
REQ-025 In DONE, SHALL hold a_out, b_out, res and cout stable until out_valid && out_ready; on that edge it SHALL return to IDLE.
REQ-026 SHALL NOT accept a new request in the same cycle as the DONE->IDLE handoff; the earliest new acceptance is the following edge.
REQ-027 SHALL make a_out and b_out equal the captured a and b from the acceptance edge onward, so that the (a,b,cin) to (a_out,b_out,res,cout) mapping is one-to-one.
REQ-028 res and cout values SHALL be meaningful only while out_valid is high; during RUN they hold partial values.
REQ-029 Outputs SHALL depend only on registered state; there SHALL be no combinational path from any input to any output.

Reset
REQ-030 While rst is high, SHALL force:
- state = IDLE;
- a_out, b_out, res, counter = 0;
- cout, out_valid, busy = 0;
- in_ready = 1.
REQ-031 A rst assertion in RUN or DONE SHALL abort the operation and discard the result, with no out_valid pulse; the first acceptance is possible on the first edge after rst deasserts.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-032 Forward overflow: a=0xFF, b=0x01, cin=0, mode=0 -> out_valid 8 edges after accept; res=0x00, cout=1, a_out=0xFF, b_out=0x01.
REQ-033 Reverse borrow: a=0x05, b=0x03, cin=1, mode=1 -> res=0xFD, cout=1, a_out=0x05, b_out=0x03.
REQ-034 Round trip: forward a=0x3C, b=0xA7, cin=1 gives res=0xE4, cout=0; reverse a=0x3C, b=0xE4, cin=1 gives res=0xA7, cout=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not captured; out_ready=1 -> IDLE next edge.
REQ-036 Reset mid-RUN: assert rst after 3 RUN edges -> all outputs 0 and in_ready=1 immediately; no out_valid afterwards; the next request completes correctly.
REQ-037 DIGIT=4: forward a=0x9A, b=0x77, cin=0 -> out_valid 2 edges after accept; res=0x11, cout=1.

Source files
------------

// File: rtl/reversible_serial_adder.sv
// Digit-serial reversible adder.
// Forward mode produces {cout,res} = a + b + cin; reverse mode uncomputes
// res = b - a - cin with cout as the borrow, so (a,b,cin) <-> (a_out,b_out,res,cout)
// is one-to-one. One DIGIT-bit slice is processed per RUN cycle, LSB slice first.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Both valids
// are held by their producer until the transfer, and readies never depend
// combinationally on the matching valid.
module reversible_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             busy
);

    localparam int NUM = WIDTH / DIGIT;
    localparam int CW  = $clog2(NUM + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             mode_q;
    logic             carry;

    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic [DIGIT:0]   slice_full;
    logic [DIGIT-1:0] slice_res;
    logic             slice_carry;

    // Status outputs are pure decodes of the registered state.
    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    // The running carry (forward) or borrow (reverse) is the carry-out once done.
    assign cout = carry;

    // One slice of add or subtract; the top bit is the carry or borrow out
    // (a negative difference wraps and sets it).
    always_comb begin
        slice_a    = a_sh[DIGIT-1:0];
        slice_b    = b_sh[DIGIT-1:0];
        slice_full = '0;
        if (mode_q) begin
            slice_full = {1'b0, slice_b} - {1'b0, slice_a} - {{DIGIT{1'b0}}, carry};
        end else begin
            slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry};
        end
        slice_res   = slice_full[DIGIT-1:0];
        slice_carry = slice_full[DIGIT];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the handoff edge back to IDLE never accepts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture on acceptance, then shift operand copies and assemble res from the top down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out  <= '0;
            b_out  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            mode_q <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_out  <= a;
                        b_out  <= b;
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        mode_q <= mode;
                        res    <= '0;
                        count  <= CW'(NUM);
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    res   <= (res >> DIGIT) | (WIDTH'(slice_res) << (WIDTH - DIGIT));
                    carry <= slice_carry;
                    count <= count - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reversible_serial_adder.sv
// Bench for reversible_serial_adder: a bit-serial (DIGIT=1) and a nibble-serial
// (DIGIT=4) instance, directed corner cases plus random traffic scored against
// an arithmetic reference.
module tb_reversible_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- shared stimulus ----------------
    logic       mode;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid1, out_ready1, in_valid4, out_ready4;

    logic [7:0] a_out1, b_out1, res1, a_out4, b_out4, res4;
    logic       cout1, out_valid1, in_ready1, busy1;
    logic       cout4, out_valid4, in_ready4, busy4;

    reversible_serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .mode(mode), .a(a), .b(b), .cin(cin), .out_valid(out_valid1),
        .out_ready(out_ready1), .a_out(a_out1), .b_out(b_out1), .res(res1),
        .cout(cout1), .busy(busy1)
    );

    reversible_serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode), .a(a), .b(b), .cin(cin), .out_valid(out_valid4),
        .out_ready(out_ready4), .a_out(a_out4), .b_out(b_out4), .res(res4),
        .cout(cout4), .busy(busy4)
    );

    // Instance under observation: 0 = DIGIT 1, 1 = DIGIT 4.
    logic       sel;
    logic [7:0] o_a, o_b, o_res;
    logic       o_cout, o_ov, o_ir, o_busy;

    always_comb begin
        o_a    = sel ? a_out4     : a_out1;
        o_b    = sel ? b_out4     : b_out1;
        o_res  = sel ? res4       : res1;
        o_cout = sel ? cout4      : cout1;
        o_ov   = sel ? out_valid4 : out_valid1;
        o_ir   = sel ? in_ready4  : in_ready1;
        o_busy = sel ? busy4      : busy1;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout,res} from plain integer arithmetic.
    function automatic logic [8:0] ref_calc(input logic [7:0] ra, input logic [7:0] rb,
                                            input logic rc, input logic rm);
        int s;
        logic borrow;
        if (!rm) begin
            s = int'(ra) + int'(rb) + int'(rc);
            return 9'(s);
        end
        s      = int'(rb) - int'(ra) - int'(rc);
        borrow = (int'(ra) + int'(rc)) > int'(rb);
        return {borrow, 8'(s)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_valid(input logic v);
        if (sel) in_valid4 = v;
        else     in_valid1 = v;
    endtask

    task automatic set_ready(input logic v);
        if (sel) out_ready4 = v;
        else     out_ready1 = v;
    endtask

    // Issue one request and wait for its result (left in DONE).
    task automatic do_op(input logic s, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tc, input logic tm);
        logic [8:0] e;
        int lat;
        int nslice;
        nslice = s ? 2 : 8;
        @(negedge clk);
        sel  = s;
        a    = ta;
        b    = tb_v;
        cin  = tc;
        mode = tm;
        set_valid(1'b1);
        #1;
        check_eq("in_ready_idle", 32'(o_ir), 32'd1);
        exp_q.push_back(ref_calc(ta, tb_v, tc, tm));
        @(posedge clk);
        #1;
        set_valid(1'b0);
        a    = 8'($urandom);
        b    = 8'($urandom);
        cin  = 1'($urandom);
        mode = 1'($urandom);
        check_eq("busy_after_accept", 32'(o_busy), 32'd1);
        check_eq("a_out_at_accept", 32'(o_a), 32'(ta));
        check_eq("b_out_at_accept", 32'(o_b), 32'(tb_v));
        lat = 0;
        while (!o_ov && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(nslice));
        e = exp_q.pop_front();
        check_eq("res", 32'(o_res), 32'(e[7:0]));
        check_eq("cout", 32'(o_cout), 32'(e[8]));
        check_eq("a_out", 32'(o_a), 32'(ta));
        check_eq("b_out", 32'(o_b), 32'(tb_v));
        check_eq("in_ready_done", 32'(o_ir), 32'd0);
    endtask

    // Take the result and confirm return to IDLE.
    task automatic release_out();
        @(negedge clk);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        set_ready(1'b0);
        check_eq("ov_after_take", 32'(o_ov), 32'd0);
        check_eq("ir_after_take", 32'(o_ir), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic seen_ov;
        rst        = 1'b1;
        sel        = 1'b0;
        mode       = 1'b0;
        cin        = 1'b0;
        a          = '0;
        b          = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(o_ir), 32'd1);
        check_eq("rst_out_valid", 32'(o_ov), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_res", 32'(o_res), 32'd0);
        check_eq("rst_a_out", 32'(o_a), 32'd0);
        check_eq("rst_cout", 32'(o_cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Forward overflow, reverse borrow, round trip.
        do_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        check_eq("ovf_res_const", 32'(o_res), 32'h00);
        check_eq("ovf_cout_const", 32'(o_cout), 32'd1);
        release_out();
        do_op(1'b0, 8'h05, 8'h03, 1'b1, 1'b1);
        check_eq("borrow_res_const", 32'(o_res), 32'hFD);
        release_out();
        do_op(1'b0, 8'h3C, 8'hA7, 1'b1, 1'b0);
        check_eq("rt_fwd_res_const", 32'(o_res), 32'hE4);
        release_out();
        do_op(1'b0, 8'h3C, 8'hE4, 1'b1, 1'b1);
        check_eq("rt_rev_res_const", 32'(o_res), 32'hA7);
        release_out();

        // Nibble-serial instance.
        do_op(1'b1, 8'h9A, 8'h77, 1'b0, 1'b0);
        check_eq("d4_res_const", 32'(o_res), 32'h11);
        release_out();

        // Backpressure: new operands offered while DONE is held.
        do_op(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        in_valid1 = 1'b1;
        a         = 8'hAA;
        b         = 8'h55;
        cin       = 1'b1;
        mode      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", 32'(o_ov), 32'd1);
            check_eq("bp_in_ready", 32'(o_ir), 32'd0);
            check_eq("bp_a_out", 32'(o_a), 32'h12);
            check_eq("bp_b_out", 32'(o_b), 32'h34);
            check_eq("bp_res", 32'(o_res), 32'h46);
        end
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("handoff_idle", 32'(o_ir), 32'd1);
        check_eq("handoff_no_accept", 32'(o_busy), 32'd0);
        check_eq("handoff_a_out", 32'(o_a), 32'h12);
        @(negedge clk);
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;

        // Reset in the middle of RUN.
        @(negedge clk);
        a         = 8'h81;
        b         = 8'h42;
        cin       = 1'b0;
        mode      = 1'b0;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ir", 32'(o_ir), 32'd1);
        check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
        check_eq("mid_rst_ov", 32'(o_ov), 32'd0);
        check_eq("mid_rst_a_out", 32'(o_a), 32'd0);
        check_eq("mid_rst_b_out", 32'(o_b), 32'd0);
        check_eq("mid_rst_res", 32'(o_res), 32'd0);
        check_eq("mid_rst_cout", 32'(o_cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (o_ov) seen_ov = 1'b1;
        end
        check_eq("no_ov_after_rst", 32'(seen_ov), 32'd0);
        do_op(1'b0, 8'h81, 8'h42, 1'b1, 1'b0);
        release_out();

        // Random traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            release_out();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
